tlc_lamp_monitor: RTL

Safety monitor and lamp driver sitting downstream of the traffic light controller FSM. It samples the 2-bit `highwaySignal`/`farmSignal` codes, decodes them to one-hot lamp drives and checks every update for conflicts, invalid codes, illegal sequences and short yellows. On any violation it locks into a flashing-red fault mode until software clears it with both roads requesting red.

---
 rtl/tlc_lamp_monitor.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/tlc_lamp_monitor.sv
// rtl/tlc_lamp_monitor.sv - lamp decoder and safety monitor behind the traffic light controller
// Registers the road codes, drives one-hot lamps and traps into flashing red on any unsafe update.
module tlc_lamp_monitor #(
    parameter int unsigned MIN_YELLOW = 150000000,
    parameter int unsigned BLINK_HALF = 25000000,
    parameter int unsigned CNT_W      = 31
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    input  logic       clearFault,
    output logic [2:0] hwyLamps,
    output logic [2:0] farmLamps,
    output logic       fault,
    output logic [1:0] faultCode,
    output logic       mode
);

    typedef enum logic {
        MONITOR = 1'b0,
        FLASH   = 1'b1
    } mode_e;

    localparam logic [1:0] SIG_INV = 2'b00;
    localparam logic [1:0] SIG_RED = 2'b01;
    localparam logic [1:0] SIG_YEL = 2'b10;
    localparam logic [1:0] SIG_GRN = 2'b11;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_CONFLICT = 2'b01;
    localparam logic [1:0] FC_INVALID  = 2'b10;
    localparam logic [1:0] FC_SEQUENCE = 2'b11;

    localparam logic [CNT_W-1:0] YEL_SAT    = CNT_W'(MIN_YELLOW);
    // The cycle in which acc is still yellow has not been counted yet, hence the -1.
    localparam logic [CNT_W-1:0] YEL_OK     = CNT_W'(MIN_YELLOW - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    function automatic logic [2:0] decode_lamp(input logic [1:0] code);
        logic [2:0] lamp;
        case (code)
            SIG_GRN: lamp = LAMP_GRN;
            SIG_YEL: lamp = LAMP_YEL;
            default: lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

    function automatic logic illegal_step(input logic [1:0] prev, input logic [1:0] nxt);
        return ((prev == SIG_GRN) && (nxt == SIG_RED)) ||
               ((prev == SIG_RED) && (nxt == SIG_YEL)) ||
               ((prev == SIG_YEL) && (nxt == SIG_GRN));
    endfunction

    function automatic logic short_yellow(input logic [1:0]       prev,
                                          input logic [1:0]       nxt,
                                          input logic [CNT_W-1:0] cnt);
        return (prev == SIG_YEL) && (nxt == SIG_RED) && (cnt < YEL_OK);
    endfunction

    function automatic logic [CNT_W-1:0] yel_count(input logic [1:0]       acc,
                                                   input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        if (acc != SIG_YEL) begin
            nxt = '0;
        end else if (cnt == YEL_SAT) begin
            nxt = cnt;
        end else begin
            nxt = cnt + CNT_W'(1);
        end
        return nxt;
    endfunction

    mode_e            mode_q, mode_d;
    logic [1:0]       cur_hwy_q, cur_hwy_d;
    logic [1:0]       cur_farm_q, cur_farm_d;
    logic [1:0]       acc_hwy_q, acc_hwy_d;
    logic [1:0]       acc_farm_q, acc_farm_d;
    logic [2:0]       hwy_lamps_q, hwy_lamps_d;
    logic [2:0]       farm_lamps_q, farm_lamps_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [CNT_W-1:0] yel_hwy_q, yel_hwy_d;
    logic [CNT_W-1:0] yel_farm_q, yel_farm_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;

    logic viol_invalid;
    logic viol_conflict;
    logic viol_sequence;
    logic both_red;

    always_comb begin
        viol_invalid  = (cur_hwy_q == SIG_INV) || (cur_farm_q == SIG_INV);
        viol_conflict = (cur_hwy_q != SIG_RED) && (cur_farm_q != SIG_RED);
        viol_sequence = illegal_step(acc_hwy_q, cur_hwy_q) ||
                        illegal_step(acc_farm_q, cur_farm_q) ||
                        short_yellow(acc_hwy_q, cur_hwy_q, yel_hwy_q) ||
                        short_yellow(acc_farm_q, cur_farm_q, yel_farm_q);
        both_red      = (cur_hwy_q == SIG_RED) && (cur_farm_q == SIG_RED);
    end

    always_comb begin
        mode_d       = mode_q;
        cur_hwy_d    = highwaySignal;
        cur_farm_d   = farmSignal;
        acc_hwy_d    = acc_hwy_q;
        acc_farm_d   = acc_farm_q;
        hwy_lamps_d  = hwy_lamps_q;
        farm_lamps_d = farm_lamps_q;
        fault_code_d = fault_code_q;
        yel_hwy_d    = yel_hwy_q;
        yel_farm_d   = yel_farm_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;

        case (mode_q)
            MONITOR: begin
                yel_hwy_d  = yel_count(acc_hwy_q, yel_hwy_q);
                yel_farm_d = yel_count(acc_farm_q, yel_farm_q);
                if (viol_invalid || viol_conflict || viol_sequence) begin
                    // acc is frozen so the offending code never reaches the lamps.
                    mode_d       = FLASH;
                    fault_code_d = viol_invalid  ? FC_INVALID  :
                                   viol_conflict ? FC_CONFLICT : FC_SEQUENCE;
                    hwy_lamps_d  = LAMP_RED;
                    farm_lamps_d = LAMP_RED;
                    blink_cnt_d  = '0;
                    blink_on_d   = 1'b1;
                end else begin
                    acc_hwy_d    = cur_hwy_q;
                    acc_farm_d   = cur_farm_q;
                    hwy_lamps_d  = decode_lamp(cur_hwy_q);
                    farm_lamps_d = decode_lamp(cur_farm_q);
                end
            end
            FLASH: begin
                if (clearFault && both_red) begin
                    mode_d       = MONITOR;
                    fault_code_d = FC_NONE;
                    acc_hwy_d    = SIG_RED;
                    acc_farm_d   = SIG_RED;
                    hwy_lamps_d  = LAMP_RED;
                    farm_lamps_d = LAMP_RED;
                    yel_hwy_d    = '0;
                    yel_farm_d   = '0;
                    blink_cnt_d  = '0;
                    blink_on_d   = 1'b1;
                end else begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_on_d  = ~blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + CNT_W'(1);
                    end
                    hwy_lamps_d  = {blink_on_d, 2'b00};
                    farm_lamps_d = {blink_on_d, 2'b00};
                end
            end
            default: mode_d = MONITOR;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mode_q       <= MONITOR;
            cur_hwy_q    <= SIG_RED;
            cur_farm_q   <= SIG_RED;
            acc_hwy_q    <= SIG_RED;
            acc_farm_q   <= SIG_RED;
            hwy_lamps_q  <= LAMP_RED;
            farm_lamps_q <= LAMP_RED;
            fault_code_q <= FC_NONE;
            yel_hwy_q    <= '0;
            yel_farm_q   <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
        end else begin
            mode_q       <= mode_d;
            cur_hwy_q    <= cur_hwy_d;
            cur_farm_q   <= cur_farm_d;
            acc_hwy_q    <= acc_hwy_d;
            acc_farm_q   <= acc_farm_d;
            hwy_lamps_q  <= hwy_lamps_d;
            farm_lamps_q <= farm_lamps_d;
            fault_code_q <= fault_code_d;
            yel_hwy_q    <= yel_hwy_d;
            yel_farm_q   <= yel_farm_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
        end
    end

    assign hwyLamps  = hwy_lamps_q;
    assign farmLamps = farm_lamps_q;
    assign fault     = (mode_q == FLASH);
    assign faultCode = fault_code_q;
    assign mode      = mode_q;

endmodule
